mem_sweep_ram: RTL and testbench

Parametrised simple-dual-port synchronous RAM: one write port, one registered read port with a valid flag, selectable read-during-write behaviour, and a hardware clear sequencer. The sequencer sweeps every word to a programmable init value after reset or on command. It replaces the fixed 16x32 single-port memory in the datapath wherever a processor register file or data store needs guaranteed-known contents and concurrent read/write.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_sweep_ctrl.sv | 73 +++++++
 rtl/mem_sweep_ram.sv | 78 +++++++
 tb/tb_mem_sweep_ram.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the sweep-cleared simple-dual-port RAM.
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } sweep_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/mem_sweep_ctrl.sv
// Clear sequencer: owns the sweep FSM and counter, and steers the single RAM
// write port between the sweep and the user write strobe.
module mem_sweep_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              p_Clock,
    input  logic              p_Reset,
    input  logic              p_Clear,
    input  logic              p_WrEn,
    input  logic [ADDR_W-1:0] p_WrAddr,
    output logic              p_Busy,
    output logic              p_Accept,
    output logic              p_MemWe,
    output logic [ADDR_W-1:0] p_MemAddr,
    output logic              p_MemInit
);

    sweep_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge p_Clock) begin
        if (p_Reset) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        p_Accept   = 1'b0;
        p_MemWe    = 1'b0;
        p_MemAddr  = p_WrAddr;
        p_MemInit  = 1'b0;
        unique case (state_reg)
            CLEAR: begin
                p_MemWe   = 1'b1;
                p_MemAddr = cnt_reg;
                p_MemInit = 1'b1;
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_reg == {ADDR_W{1'b1}}) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (p_Clear) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end else begin
                    p_Accept = 1'b1;
                    p_MemWe  = p_WrEn;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
        // Reset must never disturb stored words or let a request through.
        if (p_Reset) begin
            p_MemWe  = 1'b0;
            p_Accept = 1'b0;
        end
    end

    assign p_Busy = (state_reg == CLEAR) || p_Reset;

endmodule

// File: rtl/mem_sweep_ram.sv
// Simple-dual-port RAM with registered read, valid/reject flags, selectable
// read-during-write result and a hardware clear sweep to INIT_VAL.
module mem_sweep_ram
    import mem_pkg::*;
#(
    parameter int                WORD_W   = 16,
    parameter int                ADDR_W   = 5,
    parameter logic [WORD_W-1:0] INIT_VAL = '0,
    parameter int                RDW_MODE = 0
) (
    input  logic              p_Clock,
    input  logic              p_Reset,
    input  logic              p_Clear,
    input  logic              p_WrEn,
    input  logic [ADDR_W-1:0] p_WrAddr,
    input  logic [WORD_W-1:0] p_In,
    input  logic              p_RdEn,
    input  logic [ADDR_W-1:0] p_RdAddr,
    output logic [WORD_W-1:0] p_Output,
    output logic              p_Valid,
    output logic              p_Busy,
    output logic              p_Reject
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [WORD_W-1:0] mem [DEPTH];

    logic              accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_init;
    logic [WORD_W-1:0] mem_wdata;
    logic              rd_fire;
    logic              rdw_hit;

    mem_sweep_ctrl #(
        .ADDR_W(ADDR_W)
    ) u_ctrl (
        .p_Clock  (p_Clock),
        .p_Reset  (p_Reset),
        .p_Clear  (p_Clear),
        .p_WrEn   (p_WrEn),
        .p_WrAddr (p_WrAddr),
        .p_Busy   (p_Busy),
        .p_Accept (accept),
        .p_MemWe  (mem_we),
        .p_MemAddr(mem_addr),
        .p_MemInit(mem_init)
    );

    assign mem_wdata = mem_init ? INIT_VAL : p_In;
    assign rd_fire   = accept && p_RdEn;
    assign rdw_hit   = (RDW_MODE == RDW_NEW) && p_WrEn && (p_WrAddr == p_RdAddr);

    always_ff @(posedge p_Clock) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Write-through bypass is taken at the read register; the array itself
    // keeps plain read-first behaviour.
    always_ff @(posedge p_Clock) begin
        if (p_Reset) begin
            p_Output <= '0;
            p_Valid  <= 1'b0;
            p_Reject <= 1'b0;
        end else begin
            p_Valid  <= rd_fire;
            p_Reject <= !accept && (p_WrEn || p_RdEn);
            if (rd_fire) begin
                p_Output <= rdw_hit ? p_In : mem[p_RdAddr];
            end
        end
    end

endmodule

// File: tb/tb_mem_sweep_ram.sv
// Three RAM instances (old-data, write-through, 8x8) driven in lockstep and
// checked against directed expectations and a behavioural model.
module tb_mem_sweep_ram;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, we, re;
    logic [4:0]  wa, ra;
    logic [15:0] din;

    logic [15:0] out0, out1;
    logic [7:0]  out2;
    logic        val0, val1, val2, busy0, busy1, busy2, rej0, rej1, rej2;

    int checks = 0;
    int errors = 0;

    mem_sweep_ram #(.WORD_W(16), .ADDR_W(5), .INIT_VAL(16'hA5A5), .RDW_MODE(0)) dut0 (
        .p_Clock(clk), .p_Reset(rst), .p_Clear(clr), .p_WrEn(we), .p_WrAddr(wa),
        .p_In(din), .p_RdEn(re), .p_RdAddr(ra), .p_Output(out0), .p_Valid(val0),
        .p_Busy(busy0), .p_Reject(rej0));

    mem_sweep_ram #(.WORD_W(16), .ADDR_W(5), .INIT_VAL(16'hA5A5), .RDW_MODE(1)) dut1 (
        .p_Clock(clk), .p_Reset(rst), .p_Clear(clr), .p_WrEn(we), .p_WrAddr(wa),
        .p_In(din), .p_RdEn(re), .p_RdAddr(ra), .p_Output(out1), .p_Valid(val1),
        .p_Busy(busy1), .p_Reject(rej1));

    mem_sweep_ram #(.WORD_W(8), .ADDR_W(3), .INIT_VAL(8'h5A), .RDW_MODE(0)) dut2 (
        .p_Clock(clk), .p_Reset(rst), .p_Clear(clr), .p_WrEn(we), .p_WrAddr(wa[2:0]),
        .p_In(din[7:0]), .p_RdEn(re), .p_RdAddr(ra[2:0]), .p_Output(out2), .p_Valid(val2),
        .p_Busy(busy2), .p_Reject(rej2));

    // Behavioural model: a sweep is just "N edges of busy that fill memory".
    int          m_depth [3] = '{32, 32, 8};
    logic [15:0] m_init  [3] = '{16'hA5A5, 16'hA5A5, 16'h005A};
    int          m_mode  [3] = '{0, 1, 0};
    logic [4:0]  m_amask [3] = '{5'h1F, 5'h1F, 5'h07};
    logic [15:0] m_dmask [3] = '{16'hFFFF, 16'hFFFF, 16'h00FF};
    logic [15:0] m_mem   [3][32];
    logic [15:0] m_out   [3];
    logic        m_val   [3];
    logic        m_rej   [3];
    int          m_left  [3];

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            logic [4:0]  a_w, a_r;
            logic [15:0] d;
            a_w = wa & m_amask[i];
            a_r = ra & m_amask[i];
            d   = din & m_dmask[i];
            if (rst) begin
                m_left[i] = m_depth[i];
                m_out[i]  = '0;
                m_val[i]  = 1'b0;
                m_rej[i]  = 1'b0;
            end else if (m_left[i] > 0) begin
                m_mem[i][m_depth[i] - m_left[i]] = m_init[i];
                m_left[i] = m_left[i] - 1;
                m_rej[i]  = we | re;
                m_val[i]  = 1'b0;
            end else if (clr) begin
                m_left[i] = m_depth[i];
                m_rej[i]  = we | re;
                m_val[i]  = 1'b0;
            end else begin
                m_rej[i] = 1'b0;
                m_val[i] = re;
                if (re) m_out[i] = (m_mode[i] == 1 && we && a_w == a_r) ? d : m_mem[i][a_r];
                if (we) m_mem[i][a_w] = d;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [18:0] obs(input int i);
        case (i)
            0:       return {busy0, rej0, val0, out0};
            1:       return {busy1, rej1, val1, out1};
            default: return {busy2, rej2, val2, 8'h00, out2};
        endcase
    endfunction

    function automatic logic [18:0] expv(input int i);
        return {(m_left[i] > 0), m_rej[i], m_val[i], m_out[i]};
    endfunction

    task automatic test_reset();
        int fall0, fall2;
        rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; wa = '0; ra = '0; din = '0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs(i) !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
                errors++;
                $display("FAIL reset_state inst=%0d got=%h want=%h", i, obs(i), {1'b1, 1'b0, 1'b0, 16'h0000});
            end
        end
        rst = 1'b0;
        fall0 = 0; fall2 = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (fall2 == 0 && !busy2) fall2 = k;
            if (!busy0) begin fall0 = k; break; end
        end
        checks++;
        if (fall0 != 32) begin errors++; $display("FAIL sweep_len32 got=%0d want=32", fall0); end
        checks++;
        if (fall2 != 8) begin errors++; $display("FAIL sweep_len8 got=%0d want=8", fall2); end
        for (int a = 0; a < 32; a++) begin
            re = 1'b1; ra = 5'(a);
            tick();
            checks++;
            if (!(val0 && val1 && val2 && out0 === 16'hA5A5 && out1 === 16'hA5A5 && out2 === 8'h5A)) begin
                errors++;
                $display("FAIL init_read addr=%0d got=%h/%h/%h v=%b%b%b want=a5a5/a5a5/5a v=111",
                         a, out0, out1, out2, val0, val1, val2);
            end
        end
        re = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        we = 1'b1; wa = 5'd7; din = 16'h1234;
        tick();
        we = 1'b0; re = 1'b1; ra = 5'd7;
        tick();
        re = 1'b0;
        checks++;
        if (!(val0 && out0 === 16'h1234 && out1 === 16'h1234 && val2 && out2 === 8'h34)) begin
            errors++;
            $display("FAIL write_read got=%h/%h/%h v=%b%b want=1234/1234/34 v=11", out0, out1, out2, val0, val2);
        end
        tick();
        checks++;
        if (val0 !== 1'b0 || out0 !== 16'h1234 || rej0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got out=%h v=%b r=%b want out=1234 v=0 r=0", out0, val0, rej0);
        end
        $display("test_write_read done");
    endtask

    task automatic test_rdw();
        we = 1'b1; wa = 5'd3; din = 16'h0001;
        tick();
        re = 1'b1; ra = 5'd3; din = 16'hBEEF;
        tick();
        we = 1'b0;
        checks++;
        if (out0 !== 16'h0001 || out2 !== 8'h01) begin
            errors++;
            $display("FAIL rdw_old got=%h/%h want=0001/01", out0, out2);
        end
        checks++;
        if (out1 !== 16'hBEEF) begin
            errors++;
            $display("FAIL rdw_new got=%h want=beef", out1);
        end
        tick();
        re = 1'b0;
        checks++;
        if (out0 !== 16'hBEEF || out1 !== 16'hBEEF || out2 !== 8'hEF) begin
            errors++;
            $display("FAIL rdw_reread got=%h/%h/%h want=beef/beef/ef", out0, out1, out2);
        end
        tick();
        $display("test_rdw done");
    endtask

    task automatic test_clear_reject();
        int fall;
        clr = 1'b1; we = 1'b1; wa = 5'd5; din = 16'hFFFF;
        tick();
        clr = 1'b0;
        checks++;
        if (!(busy0 && rej0 && !val0 && busy1 && rej1 && busy2 && rej2)) begin
            errors++;
            $display("FAIL clear_edge got busy=%b%b%b rej=%b%b%b v=%b want busy=111 rej=111 v=0",
                     busy0, busy1, busy2, rej0, rej1, rej2, val0);
        end
        fall = 0;
        for (int k = 1; k <= 40; k++) begin
            we = (k <= 5); wa = 5'($urandom); din = 16'($urandom);
            tick();
            if (k <= 6) begin
                checks++;
                if (rej0 !== (k <= 5) || val0 !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_reject k=%0d got r=%b v=%b want r=%b v=0", k, rej0, val0, (k <= 5));
                end
            end
            if (!busy0) begin fall = k; break; end
        end
        we = 1'b0;
        checks++;
        if (fall != 32) begin errors++; $display("FAIL clear_len got=%0d want=32", fall); end
        for (int a = 0; a < 32; a++) begin
            re = 1'b1; ra = 5'(a);
            tick();
            checks++;
            if (!(val0 && out0 === 16'hA5A5 && out1 === 16'hA5A5 && out2 === 8'h5A)) begin
                errors++;
                $display("FAIL clear_read addr=%0d got=%h/%h/%h want=a5a5/a5a5/5a", a, out0, out1, out2);
            end
        end
        re = 1'b0;
        $display("test_clear_reject done");
    endtask

    task automatic test_reset_mid_sweep();
        int fall;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out0 !== 16'h0000 || val0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got out=%h v=%b busy=%b want out=0000 v=0 busy=1", out0, val0, busy0);
        end
        fall = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (!busy0) begin fall = k; break; end
        end
        checks++;
        if (fall != 32) begin errors++; $display("FAIL mid_reset_len got=%0d want=32", fall); end
        $display("test_reset_mid_sweep done");
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            clr = ($urandom_range(0, 79) == 0);
            we  = 1'($urandom);
            re  = 1'($urandom);
            wa  = 5'($urandom);
            ra  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            din = 16'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL random n=%0d inst=%0d got=%h want=%h", n, i, obs(i), expv(i));
                end
            end
            checks++;
            if (val0 && rej0) begin
                errors++;
                $display("FAIL valid_reject n=%0d got v=1 r=1 want not both", n);
            end
        end
        rst = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rdw();
        test_clear_reject();
        test_reset_mid_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
